isi_hist_ctrl: RTL and testbench

ISI_HIST_CTRL -- requirements
Module: isi_hist_ctrl

---
 rtl/isi_hist_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_isi_hist_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/isi_hist_ctrl.sv
// Inter-spike-interval histogram controller: read-modify-write bin increments against an
// external 2-cycle-latency RAM, with clear sweep and readout. Define ISI_HIST_SAT_EN to saturate bins.
module isi_hist_ctrl #(
    parameter int BIT_ISI = 8,
    parameter int BIT_ACC = 19
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               ev_valid,
    output logic               ev_ready,
    input  logic [BIT_ISI-1:0] ev_bin,
    output logic [BIT_ISI-1:0] ram_raddr,
    input  logic [BIT_ACC-1:0] ram_rdata,
    output logic               ram_we,
    output logic [BIT_ISI-1:0] ram_waddr,
    output logic [BIT_ACC-1:0] ram_wdata,
    input  logic               clr_req,
    input  logic               dump_req,
    input  logic               dump_clr,
    output logic               busy,
    output logic               dump_valid,
    output logic [BIT_ISI-1:0] dump_bin,
    output logic [BIT_ACC-1:0] dump_data,
    output logic               ovf
);

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DUMP  = 2'd3;

    localparam logic [BIT_ISI-1:0] BIN_LAST = '1;
    localparam logic [BIT_ISI-1:0] BIN_ONE  = BIT_ISI'(1);
    localparam logic [BIT_ACC-1:0] ACC_MAX  = '1;
    localparam logic [BIT_ACC-1:0] ACC_ONE  = BIT_ACC'(1);

    logic [1:0]         state;
    logic [BIT_ISI-1:0] bin_cnt;
    logic               armed;
    logic               drain_to_clr;
    logic               dclr_q;
    logic               dump_stop;
    logic               ovf_q;

    // Event pipeline: stage 1 = read issued last cycle, stage 2 = read data present now.
    logic               p1_vld, p2_vld;
    logic [BIT_ISI-1:0] p1_bin, p2_bin;
    logic               d1_vld, d2_vld;
    logic [BIT_ISI-1:0] d1_bin, d2_bin;

    // Writes of the previous (fw1) and second-previous (fw2) cycle, for read-after-write bypass.
    logic               fw1_vld, fw2_vld;
    logic [BIT_ISI-1:0] fw1_addr, fw2_addr;
    logic [BIT_ACC-1:0] fw1_data, fw2_data;

    logic               accept;
    logic [BIT_ACC-1:0] operand;
    logic [BIT_ACC-1:0] inc;
    logic               at_max;

    assign ev_ready   = (state == ST_RUN);
    assign busy       = (state != ST_RUN);
    assign accept     = ev_valid & ev_ready;
    assign dump_valid = d2_vld;
    assign dump_bin   = d2_bin;
    assign dump_data  = d2_vld ? ram_rdata : '0;
    assign ovf        = ovf_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ram_raddr = '0;
        if (state == ST_RUN)
            ram_raddr = ev_bin;
        else if (state == ST_DUMP && !dump_stop)
            ram_raddr = bin_cnt;
    end

    // The newer write wins; the RAM read issued two cycles ago cannot see either write.
    always_comb begin
        operand = ram_rdata;
        if (fw1_vld && fw1_addr == p2_bin)
            operand = fw1_data;
        else if (fw2_vld && fw2_addr == p2_bin)
            operand = fw2_data;
        at_max = (operand == ACC_MAX);
`ifdef ISI_HIST_SAT_EN
        inc = at_max ? ACC_MAX : operand + ACC_ONE;
`else
        inc = operand + ACC_ONE;
`endif
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        if (state == ST_CLEAR && armed) begin
            ram_we    = 1'b1;
            ram_waddr = bin_cnt;
        end else if (p2_vld) begin
            ram_we    = 1'b1;
            ram_waddr = p2_bin;
            ram_wdata = inc;
        end else if (d2_vld && dclr_q) begin
            ram_we    = 1'b1;
            ram_waddr = d2_bin;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state        <= ST_CLEAR;
            bin_cnt      <= '0;
            armed        <= 1'b0;
            drain_to_clr <= 1'b0;
            dclr_q       <= 1'b0;
            dump_stop    <= 1'b0;
            ovf_q        <= 1'b0;
            p1_vld       <= 1'b0;
            p2_vld       <= 1'b0;
            p1_bin       <= '0;
            p2_bin       <= '0;
            d1_vld       <= 1'b0;
            d2_vld       <= 1'b0;
            d1_bin       <= '0;
            d2_bin       <= '0;
            fw1_vld      <= 1'b0;
            fw2_vld      <= 1'b0;
            fw1_addr     <= '0;
            fw2_addr     <= '0;
            fw1_data     <= '0;
            fw2_data     <= '0;
        end else begin
            // armed holds off the first clear write until one edge after reset release.
            armed    <= 1'b1;
            fw1_vld  <= ram_we;
            fw1_addr <= ram_waddr;
            fw1_data <= ram_wdata;
            fw2_vld  <= fw1_vld;
            fw2_addr <= fw1_addr;
            fw2_data <= fw1_data;
            p1_vld   <= accept;
            p1_bin   <= ev_bin;
            p2_vld   <= p1_vld;
            p2_bin   <= p1_bin;
            d1_vld   <= 1'b0;
            d2_vld   <= d1_vld;
            d2_bin   <= d1_bin;

            if (p2_vld && at_max)
                ovf_q <= 1'b1;

            case (state)
                ST_CLEAR: begin
                    ovf_q <= 1'b0;
                    if (armed) begin
                        bin_cnt <= bin_cnt + BIN_ONE;
                        if (bin_cnt == BIN_LAST)
                            state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (clr_req) begin
                        state        <= ST_DRAIN;
                        drain_to_clr <= 1'b1;
                    end else if (dump_req) begin
                        state        <= ST_DRAIN;
                        drain_to_clr <= 1'b0;
                        dclr_q       <= dump_clr;
                    end
                end
                ST_DRAIN: begin
                    if (clr_req)
                        drain_to_clr <= 1'b1;
                    if (!p1_vld && !p2_vld) begin
                        bin_cnt   <= '0;
                        dump_stop <= 1'b0;
                        state     <= (drain_to_clr || clr_req) ? ST_CLEAR : ST_DUMP;
                    end
                end
                ST_DUMP: begin
                    if (clr_req) begin
                        // The beat on the port this cycle completes; reads still in flight are dropped.
                        state   <= ST_CLEAR;
                        bin_cnt <= '0;
                        d2_vld  <= 1'b0;
                    end else if (!dump_stop) begin
                        d1_vld  <= 1'b1;
                        d1_bin  <= bin_cnt;
                        bin_cnt <= bin_cnt + BIN_ONE;
                        if (bin_cnt == BIN_LAST)
                            dump_stop <= 1'b1;
                    end else if (d2_vld && !d1_vld) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_isi_hist_ctrl.sv
// Directed bench for isi_hist_ctrl with a 2-cycle read-before-write RAM model.
// Expected values follow ISI_HIST_SAT_EN when it is defined for the build.
module tb_isi_hist_ctrl;

    localparam int BIT_ISI = 8;
    localparam int BIT_ACC = 19;
    localparam int NBINS   = 1 << BIT_ISI;
    localparam logic [BIT_ACC-1:0] ACC_MAX = '1;
`ifdef ISI_HIST_SAT_EN
    localparam int OVF_EXP = int'(ACC_MAX);
`else
    localparam int OVF_EXP = 0;
`endif

    logic               clk = 1'b0;
    logic               clr_n;
    logic               ev_valid;
    logic               ev_ready;
    logic [BIT_ISI-1:0] ev_bin;
    logic [BIT_ISI-1:0] ram_raddr;
    logic [BIT_ACC-1:0] ram_rdata;
    logic               ram_we;
    logic [BIT_ISI-1:0] ram_waddr;
    logic [BIT_ACC-1:0] ram_wdata;
    logic               clr_req;
    logic               dump_req;
    logic               dump_clr;
    logic               busy;
    logic               dump_valid;
    logic [BIT_ISI-1:0] dump_bin;
    logic [BIT_ACC-1:0] dump_data;
    logic               ovf;

    logic [BIT_ACC-1:0] mem [0:NBINS-1];
    logic [BIT_ACC-1:0] rd_q1;
    logic               pl_en;
    logic [BIT_ISI-1:0] pl_addr;
    logic [BIT_ACC-1:0] pl_data;
    logic [BIT_ISI-1:0] wlog_addr [0:4095];
    logic [BIT_ACC-1:0] wlog_data [0:4095];
    int                 wlog_n = 0;

    int tests = 0;
    int fails = 0;
    int hist_exp [0:NBINS-1];

    isi_hist_ctrl #(.BIT_ISI(BIT_ISI), .BIT_ACC(BIT_ACC)) dut (
        .clk(clk), .clr_n(clr_n),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_bin(ev_bin),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .clr_req(clr_req), .dump_req(dump_req), .dump_clr(dump_clr),
        .busy(busy), .dump_valid(dump_valid), .dump_bin(dump_bin), .dump_data(dump_data),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    // RAM: read data two edges after the address, old contents returned on a same-cycle write.
    always @(posedge clk) begin
        rd_q1     <= mem[ram_raddr];
        ram_rdata <= rd_q1;
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
            if (wlog_n < 4096) begin
                wlog_addr[wlog_n] <= ram_waddr;
                wlog_data[wlog_n] <= ram_wdata;
            end
            wlog_n <= wlog_n + 1;
        end
        if (pl_en)
            mem[pl_addr] <= pl_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    task automatic send(input int b);
        @(negedge clk);
        ev_valid = 1'b1;
        ev_bin   = BIT_ISI'(b);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        ev_valid = 1'b0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_writes(input string tag, input int base, input int addrs[5],
                                input int datas[5], input int n);
        chk({tag, "_count"}, 32'(wlog_n - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, 32'(wlog_addr[base + i]), 32'(addrs[i]));
            chk({tag, "_data"}, 32'(wlog_data[base + i]), 32'(datas[i]));
        end
    endtask

    // Issues a dump, collects beats against hist_exp, optionally aborts with clr_req after beat abort_bin.
    task automatic do_dump(input logic dclr, input logic stream, input int abort_bin,
                           output int beats, output int errs);
        bit done;
        beats = 0;
        errs  = 0;
        done  = 1'b0;
        if (stream)
            for (int b = 10; b < 13; b++) send(b);
        @(negedge clk);
        dump_req = 1'b1;
        dump_clr = dclr;
        ev_bin   = BIT_ISI'(13);
        @(negedge clk);
        dump_req = 1'b0;
        dump_clr = 1'b0;
        ev_bin   = BIT_ISI'(14);
        #1;
        chk("ev_ready_drop", 32'(ev_ready), 32'(0));
        for (int cyc = 0; cyc < 700 && !done; cyc++) begin
            @(negedge clk);
            ev_valid = 1'b0;
            clr_req  = 1'b0;
            #1;
            if (dump_valid === 1'b1) begin
                if (beats >= NBINS || dump_bin !== BIT_ISI'(beats) ||
                    dump_data !== BIT_ACC'(hist_exp[beats]))
                    errs++;
                if (beats == abort_bin)
                    clr_req = 1'b1;
                beats++;
            end
            if (ev_ready === 1'b1)
                done = 1'b1;
        end
        chk("dump_returns_run", 32'(done), 32'(1));
    endtask

    initial begin
        int base;
        int good;
        int beats;
        int errs;
        clr_n    = 1'b0;
        ev_valid = 1'b0;
        ev_bin   = '0;
        clr_req  = 1'b0;
        dump_req = 1'b0;
        dump_clr = 1'b0;
        pl_en    = 1'b0;
        pl_addr  = '0;
        pl_data  = '0;
        for (int i = 0; i < NBINS; i++) hist_exp[i] = 0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_ev_ready", 32'(ev_ready), 32'(0));
        chk("rst_busy", 32'(busy), 32'(1));
        chk("rst_ram_we", 32'(ram_we), 32'(0));
        chk("rst_dump_valid", 32'(dump_valid), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        chk("rst_raddr", 32'(ram_raddr), 32'(0));
        chk("rst_waddr", 32'(ram_waddr), 32'(0));
        chk("rst_wdata", 32'(ram_wdata), 32'(0));
        chk("rst_dump_bin", 32'(dump_bin), 32'(0));
        chk("rst_dump_data", 32'(dump_data), 32'(0));

        // Release: cycles 1..256 write zero to bins 0..255, ready on cycle 257.
        clr_n = 1'b1;
        good  = 0;
        for (int k = 1; k <= NBINS; k++) begin
            @(negedge clk);
            #1;
            if (ram_we === 1'b1 && ram_waddr === BIT_ISI'(k - 1) && ram_wdata === '0 &&
                ev_ready === 1'b0 && busy === 1'b1)
                good++;
        end
        chk("clear_sweep_writes", 32'(good), 32'(NBINS));
        @(negedge clk);
        #1;
        chk("ready_cycle_257", 32'(ev_ready), 32'(1));
        chk("busy_cycle_257", 32'(busy), 32'(0));

        base = wlog_n;
        for (int i = 0; i < 4; i++) send(5);
        idle(4);
        check_writes("same_bin", base, '{5, 5, 5, 5, 0}, '{1, 2, 3, 4, 0}, 4);
        hist_exp[5] = 4;

        base = wlog_n;
        send(7); send(9); send(7); send(9); send(7);
        idle(4);
        check_writes("alt_bins", base, '{7, 9, 7, 9, 7}, '{1, 1, 2, 2, 3}, 5);
        hist_exp[7] = 3;
        hist_exp[9] = 2;

        chk("ovf_before", 32'(ovf), 32'(0));
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = BIT_ISI'(3);
        pl_data = ACC_MAX;
        @(negedge clk);
        pl_en = 1'b0;
        send(3);
        idle(3);
        chk("ovf_set", 32'(ovf), 32'(1));
        chk("ovf_bin3", 32'(mem[3]), 32'(OVF_EXP));
        hist_exp[3] = OVF_EXP;

        do_dump(1'b0, 1'b0, -1, beats, errs);
        chk("dump1_beats", 32'(beats), 32'(NBINS));
        chk("dump1_errs", 32'(errs), 32'(0));
        chk("ovf_sticky", 32'(ovf), 32'(1));

        // Dump with clear while events are streaming: bins 10..13 retire before the readout.
        for (int b = 10; b <= 13; b++) hist_exp[b] = 1;
        do_dump(1'b1, 1'b1, -1, beats, errs);
        chk("dump_clr_beats", 32'(beats), 32'(NBINS));
        chk("dump_clr_errs", 32'(errs), 32'(0));
        for (int i = 0; i < NBINS; i++) hist_exp[i] = 0;

        do_dump(1'b0, 1'b0, -1, beats, errs);
        chk("dump_after_clr_beats", 32'(beats), 32'(NBINS));
        chk("dump_after_clr_errs", 32'(errs), 32'(0));

        send(200);
        send(50);
        idle(3);
        hist_exp[200] = 1;
        hist_exp[50]  = 1;
        do_dump(1'b0, 1'b0, 100, beats, errs);
        chk("abort_beats", 32'(beats), 32'(101));
        chk("abort_errs", 32'(errs), 32'(0));
        chk("abort_ovf_cleared", 32'(ovf), 32'(0));
        for (int i = 0; i < NBINS; i++) hist_exp[i] = 0;

        do_dump(1'b0, 1'b0, -1, beats, errs);
        chk("post_abort_beats", 32'(beats), 32'(NBINS));
        chk("post_abort_errs", 32'(errs), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
